clock_divider_bank: RTL
=======================

// Module: clock_divider_bank
// PURPOSE
//  Bank of N_CH independent, synthesizable clock-enable-style clock generators driven from one
//  source clock. Each channel has a runtime-programmable period, high time (duty) and start phase.
//  Channels start and stop glitch-free and can be realigned together by a sync pulse.
//  Used in tb_common_module, and by DUT-side stubs that need cycle-exact derived clocks.
// PARAMETERS
//  N_CH   4  number of output channels (>=1)
//  CNT_W  8  width of div/high/phase counters; max period 2**CNT_W-1 source cycles
//  CH_W   $clog2(N_CH) (min 1), localparam: channel index width
// PORTS
//  clk        in   1      source clock; all logic on posedge
//  rst_n      in   1      asynchronous active-low reset
//  cfg_valid  in   1      config write strobe, one write per cycle
//  cfg_ch     in   CH_W   target channel of the write
//  cfg_div    in   CNT_W  period in clk cycles
//  cfg_high   in   CNT_W  high cycles per period
//  cfg_phase  in   CNT_W  start delay in clk cycles after enable/sync
//  cfg_err    out  1      1-cycle pulse: last write rejected
//  ch_en      in   N_CH   per-channel run enable, level
//  sync       in   1      1-cycle realign pulse for all non-idle channels
//  clk_out    out  N_CH   generated clocks, registered
//  edge_rise  out  N_CH   1-cycle pulse, same edge clk_out[i] goes 0->1
//  ch_active  out  N_CH   1 while channel in PHASE or RUN
// BEHAVIOUR
//  Reset: clk_out, edge_rise, ch_active, cfg_err = 0; all channels IDLE.
//   Active and pending cfg reset to div=2, high=1, phase=0.
//  Config validity: 2<=div, 1<=high<=div-1, phase<=div-1, cfg_ch<N_CH.
//   Invalid write: cfg_err=1 on the next edge; no state changes.
//  Valid write goes to the channel's pending register; later writes overwrite it (last wins).
//   Pending is copied to active:
//   - immediately if the channel is IDLE;
//   - at period wrap in RUN;
//   - on sync.
//   Never mid-period, so no runt pulses.
//  Per-channel FSM, evaluated each posedge:
//   IDLE : clk_out=0. ch_en=1 -> PHASE with pcnt=0.
//   PHASE: clk_out=0.
//          - pcnt==phase -> RUN, cnt=0, clk_out<=1, edge_rise<=1.
//          - else pcnt++.
//          - ch_en=0 in PHASE -> IDLE.
//   RUN  : cnt_n = (cnt==div-1) ? 0 : cnt+1; clk_out <= (cnt_n < high).
//          - Wrap (cnt==div-1) with ch_en=0 -> IDLE, clk_out<=0. The current period always completes.
//          - Wrap with ch_en=1 applies pending cfg first; cnt_n and compare use the new values.
//  Latency: ch_en sampled at edge k (phase=P) -> first clk_out rise at edge k+1+P.
//  Steady state: period = div cycles, high = high cycles, low = div-high cycles.
//  sync=1: every channel in PHASE/RUN -> PHASE, pcnt=0, clk_out<=0, pending applied.
//   All enabled channels then rise phase+1 edges later. IDLE channels ignore sync.
//   cfg_valid with sync in the same cycle: the write is captured first, so the new value applies.
//  ch_en deassert then reassert before wrap: treated as continuous run (en is sampled only at wrap).
//  edge_rise is never asserted when clk_out was already 1.
//   Example: div=2, high=1 gives 1010..., with edge_rise every 2 cycles.
//  rst_n low mid-period: outputs drop to 0 asynchronously. No pending/active cfg survives.
// TESTING
//  1 ch0 div=4 high=2 phase=0, ch_en[0]=1 at edge 10 -> clk_out[0] rises edge 11.
//    Pattern 1100 repeats; edge_rise at 11, 15, 19.
//  2 ch1 div=5 high=1 phase=3, ch2 div=3 high=2 phase=0, both enabled same edge k.
//    -> ch1 rises at k+4, k+9; ch2 rises at k+1, k+4.
//  3 ch0 running div=4/high=2; write div=6 high=3 at cnt=1.
//    -> current period stays 4 cycles; next period is 111000; cfg_err=0.
//  4 Rejected writes -> cfg_err pulse each, clk_out unchanged:
//    div=1; high=0; high=div; phase=div; cfg_ch=N_CH (if N_CH not power of 2).
//  5 ch_en[0] dropped at cnt=1 of div=4 -> two more cycles (cnt=2,3) at 0.
//    Then IDLE, ch_active[0]=0; no glitch.
//  6 Channels running with phases 0 and 2, then sync -> both clk_out 0 next edge.
//    Rises at +1 and +3 edges. Assert rst_n low mid-high -> all outputs 0 immediately.
//    After release, outputs stay 0 until ch_en is set.

Source files
------------

// File: rtl/clock_divider_bank.sv
// Bank of N_CH programmable clock generators sharing one source clock.
// Each channel has a period, a high time and a start phase; config changes take effect only on period boundaries.
module clock_divider_bank #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_phase,
  output logic              cfg_err,
  input  logic [N_CH-1:0]   ch_en,
  input  logic              sync,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   edge_rise,
  output logic [N_CH-1:0]   ch_active
);

  typedef enum logic [1:0] {
    IDLE,
    PHASE,
    RUN
  } state_t;

  logic cfg_ok;

  always_comb begin
    cfg_ok = (cfg_div >= CNT_W'(2)) && (cfg_high != '0) && (cfg_high < cfg_div) &&
             (cfg_phase < cfg_div) && (32'(cfg_ch) < N_CH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= cfg_valid && !cfg_ok;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           state, state_nx;
    logic [CNT_W-1:0] pend_div, pend_high, pend_phase;
    logic [CNT_W-1:0] pnx_div, pnx_high, pnx_phase;
    logic [CNT_W-1:0] act_div, act_high, act_phase;
    logic [CNT_W-1:0] anx_div, anx_high, anx_phase;
    logic [CNT_W-1:0] pcnt, pcnt_nx, cnt, cnt_nx;
    logic             out_q, out_nx, rise_q, wr;

    assign wr = cfg_valid && cfg_ok && (cfg_ch == CH_W'(i));

    // Pending next-value includes this cycle's write so a same-cycle sync or idle load sees it.
    always_comb begin
      pnx_div   = wr ? cfg_div   : pend_div;
      pnx_high  = wr ? cfg_high  : pend_high;
      pnx_phase = wr ? cfg_phase : pend_phase;
    end

    always_comb begin
      state_nx  = state;
      pcnt_nx   = pcnt;
      cnt_nx    = cnt;
      out_nx    = out_q;
      anx_div   = act_div;
      anx_high  = act_high;
      anx_phase = act_phase;
      unique case (state)
        IDLE: begin
          out_nx    = 1'b0;
          anx_div   = pnx_div;
          anx_high  = pnx_high;
          anx_phase = pnx_phase;
          if (ch_en[i]) begin
            state_nx = PHASE;
            pcnt_nx  = '0;
          end
        end
        PHASE: begin
          out_nx = 1'b0;
          if (!ch_en[i]) begin
            state_nx = IDLE;
          end else if (pcnt == act_phase) begin
            state_nx = RUN;
            cnt_nx   = '0;
            out_nx   = 1'b1;
          end else begin
            pcnt_nx = pcnt + 1'b1;
          end
        end
        RUN: begin
          if (cnt == act_div - 1'b1) begin
            cnt_nx = '0;
            if (!ch_en[i]) begin
              state_nx = IDLE;
              out_nx   = 1'b0;
            end else begin
              anx_div   = pnx_div;
              anx_high  = pnx_high;
              anx_phase = pnx_phase;
              out_nx    = (pnx_high != '0);
            end
          end else begin
            cnt_nx = cnt + 1'b1;
            out_nx = ((cnt + 1'b1) < act_high);
          end
        end
        default: begin
          state_nx = IDLE;
          out_nx   = 1'b0;
        end
      endcase
      // Realign overrides normal sequencing for any channel that is not idle.
      if (sync && (state != IDLE)) begin
        state_nx  = PHASE;
        pcnt_nx   = '0;
        out_nx    = 1'b0;
        anx_div   = pnx_div;
        anx_high  = pnx_high;
        anx_phase = pnx_phase;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state      <= IDLE;
        pend_div   <= CNT_W'(2);
        pend_high  <= CNT_W'(1);
        pend_phase <= '0;
        act_div    <= CNT_W'(2);
        act_high   <= CNT_W'(1);
        act_phase  <= '0;
        pcnt       <= '0;
        cnt        <= '0;
        out_q      <= 1'b0;
        rise_q     <= 1'b0;
      end else begin
        state      <= state_nx;
        pend_div   <= pnx_div;
        pend_high  <= pnx_high;
        pend_phase <= pnx_phase;
        act_div    <= anx_div;
        act_high   <= anx_high;
        act_phase  <= anx_phase;
        pcnt       <= pcnt_nx;
        cnt        <= cnt_nx;
        out_q      <= out_nx;
        rise_q     <= out_nx && !out_q;
      end
    end

    assign clk_out[i]   = out_q;
    assign edge_rise[i] = rise_q;
    assign ch_active[i] = (state != IDLE);
  end

endmodule
